core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the core datapath. Fetches each instruction over a req/ack port.
//  Holds it in inst_q, which drives the decoder. Steps FETCH->DECODE->EXEC->[MEM]->WB.
//  Owns the PC, data-memory handshake, register-file write enable and retired-instruction count.
//  Sits between the memories and the decode/ALU/regfile datapath.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  TRAP_VEC     32'h0000_0010  PC loaded on trap (TRAP_ILLEGAL_EN only)
//  ACK_TIMEOUT  16             max wait cycles for imem_ack/dmem_ack before bus_err
// PORTS
//  clk           in   1   core clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  imem_req      out  1   instruction fetch request, held until imem_ack
//  imem_addr     out  32  fetch address (= pc)
//  imem_rdata    in   32  fetched word, valid when imem_ack=1
//  imem_ack      in   1   fetch complete
//  inst_q        out  32  latched instruction to decoder
//  pc            out  32  current instruction address
//  pc_target     in   32  branch/jump target computed by datapath (pc+imm_B/imm_J, rs1+imm_I)
//  br_taken      in   1   branch condition result, sampled in EXEC
//  dmem_req      out  1   load/store request, held until dmem_ack
//  dmem_we       out  1   1=store, 0=load; valid with dmem_req
//  dmem_ack      in   1   data access complete
//  rf_we         out  1   regfile write strobe, one cycle in WB
//  instret       out  32  retired instruction count
//  halted        out  1   EBREAK retired; sticky until reset
//  bus_err       out  1   ack timeout; sticky until reset
//  trap          out  1   one-cycle pulse on illegal opcode (TRAP_ILLEGAL_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, inst_q=32'h0000_0013 (NOP).
//   All strobes/flags 0, instret=0, timeout counter 0. Reset mid-handshake drops req immediately.
//  FETCH: imem_req=1, imem_addr=pc. On imem_ack: inst_q<=imem_rdata, ->DECODE.
//  DECODE: 1 cycle, datapath settles imm/rs. Opcode=inst_q[6:0]. ->EXEC.
//  EXEC: 1 cycle. Next-PC is chosen here:
//   - BRANCH 1100011: pc_target if br_taken, else pc+4.
//   - JAL 1101111 / JALR 1100111: always pc_target.
//   - Any other opcode: pc+4.
//   LOAD 0000011 / STORE 0100011 ->MEM. All others ->WB.
//  MEM: dmem_req=1, dmem_we=(STORE). On dmem_ack ->WB.
//  WB: pc<=next-PC, instret+=1 (wraps at 2^32).
//   rf_we=1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR and inst_q[11:7]!=0. Else 0.
//   SYSTEM 1110011 with inst_q[31:7]==25'h0002000 (EBREAK) ->HALT. Else ->FETCH.
//  HALT: all strobes 0, halted=1, pc frozen. Exits only via reset.
//  Timeout: counter clears on entering FETCH/MEM and counts each cycle without ack.
//   When the counter reaches ACK_TIMEOUT with no ack: bus_err=1, ->HALT, no retire.
//   Ack on the same cycle the counter hits ACK_TIMEOUT counts as success.
//  Ack outside FETCH/MEM is ignored. imem_req and dmem_req are never both 1.
//  pc+4 wraps modulo 2^32. pc_target[1:0] are forced to 0.
//  Total latency: 4 cycles for ALU/branch ops, 5 for load/store, each plus memory wait cycles.
// CONFIGURATION
//  CORE_SEQ_TRAP_ILLEGAL_EN defined:
//   Opcodes outside the 10 listed (incl. MISC-MEM) go DECODE->TRAP.
//   TRAP: trap=1 for one cycle, pc<=TRAP_VEC, no rf_we, no retire, ->FETCH.
//  Undefined: unknown opcodes act as NOP (pc+4, rf_we=0, retired). trap tied 0.
// TESTING
//  1. Reset, imem returns 0x00500093 (addi x1,x0,5) with 0-wait ack.
//     -> rf_we pulses in cycle 4, pc=0x4, instret=1.
//  2. beq 0x00000463 with br_taken=1, pc_target=0x8 -> pc=0x8 after WB.
//     Same with br_taken=0 -> pc=0x4, rf_we stays 0.
//  3. lw 0x0000A103, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0.
//     rf_we 1 cycle after ack. sw 0x0020A023 -> dmem_we=1, rf_we=0.
//  4. imem_ack never asserted -> bus_err=1 after 16 cycles, state HALT, instret unchanged.
//  5. EBREAK 0x00100073 -> halted=1, instret incremented, no further imem_req.
//     Assert rst_n=0 mid-FETCH -> imem_req drops same cycle, pc=RESET_PC.
//  6. Opcode 0x0000007F: with CORE_SEQ_TRAP_ILLEGAL_EN -> trap pulse, pc=0x10, instret unchanged.
//     Without -> pc=0x4, instret+1.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer that owns the PC, the memory handshakes and the retire count.
// Define CORE_SEQ_TRAP_ILLEGAL_EN to trap on unknown opcodes; otherwise they retire as NOPs.
module core_seq_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0010,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] inst_q,
   output logic [31:0] pc,
   input  logic [31:0] pc_target,
   input  logic        br_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [31:0] instret,
   output logic        halted,
   output logic        bus_err,
   output logic        trap
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
   } state_t;

   state_t         state, state_nxt;
   logic [31:0]    npc_q;
   logic [CW-1:0]  tmo_cnt;
   logic [6:0]     opcode;
   logic [4:0]     rd;
   logic [31:0]    pc_plus4;
   logic [31:0]    target_al;
   logic           writes_rd;
   logic           is_ebreak;
   logic           tmo_hit;
   logic           waiting;

   assign opcode    = inst_q[6:0];
   assign rd        = inst_q[11:7];
   assign pc_plus4  = pc + 32'd4;
   assign target_al = pc_target & 32'hFFFF_FFFC;
   assign writes_rd = opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
   assign is_ebreak = (opcode == OP_SYSTEM) && (inst_q[31:7] == 25'h0002000);
   assign tmo_hit   = (tmo_cnt == CNT_LAST);
   assign waiting   = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);
   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
   logic known_op;
   assign known_op = opcode inside {OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
                                    OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
`endif

   // Request strobes are gated by rst_n so a reset mid-handshake drops them without waiting for a clock.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      trap      = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = rst_n;
            if (imem_ack)     state_nxt = S_DECODE;
            else if (tmo_hit) state_nxt = S_HALT;
         end
         S_DECODE: begin
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
            state_nxt = known_op ? S_EXEC : S_TRAP;
`else
            state_nxt = S_EXEC;
`endif
         end
         S_EXEC: state_nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req = rst_n;
            dmem_we  = rst_n && (opcode == OP_STORE);
            if (dmem_ack)     state_nxt = S_WB;
            else if (tmo_hit) state_nxt = S_HALT;
         end
         S_WB: begin
            rf_we     = writes_rd && (rd != 5'd0);
            state_nxt = is_ebreak ? S_HALT : S_FETCH;
         end
         S_HALT: state_nxt = S_HALT;
         S_TRAP: begin
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
            trap = 1'b1;
`endif
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         inst_q  <= NOP;
         npc_q   <= RESET_PC;
         instret <= 32'd0;
         bus_err <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH: if (imem_ack) inst_q <= imem_rdata;
            S_EXEC: begin
               case (opcode)
                  OP_BRANCH:       npc_q <= br_taken ? target_al : pc_plus4;
                  OP_JAL, OP_JALR: npc_q <= target_al;
                  default:         npc_q <= pc_plus4;
               endcase
            end
            S_WB: begin
               pc      <= npc_q;
               instret <= instret + 32'd1;
            end
            S_TRAP:  pc <= TRAP_VEC;
            default: ;
         endcase
         // Counter is zero whenever we are outside a handshake, so it starts fresh on entry to FETCH/MEM.
         if (waiting) begin
            if (tmo_hit) bus_err <= 1'b1;
            tmo_cnt <= tmo_cnt + CNT_ONE;
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   logic unused_misc;
   assign unused_misc = (opcode == OP_MISC);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: stimulus pushes expected retire records, a negedge monitor pops and compares.
module tb_core_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] inst_q, pc, pc_target, instret;
   logic        br_taken, dmem_req, dmem_we, dmem_ack, rf_we, halted, bus_err, trap;

   always #5 clk = ~clk;

   core_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .inst_q(inst_q), .pc(pc), .pc_target(pc_target), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .instret(instret), .halted(halted), .bus_err(bus_err), .trap(trap)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instret;
      int          rf;
      int          dreq;
      int          dwe;
      int          trapn;
      int          cycles;
      logic        bus_err;
      logic        halted;
   } rec_t;

   rec_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic rec_t mk(input logic [31:0] p, input logic [31:0] r, input int rf, input int dreq,
                               input int dwe, input int trapn, input int cyc, input logic be, input logic h);
      rec_t x;
      x.pc = p; x.instret = r; x.rf = rf; x.dreq = dreq; x.dwe = dwe;
      x.trapn = trapn; x.cycles = cyc; x.bus_err = be; x.halted = h;
      return x;
   endfunction

   // Monitor: an event is a PC/instret change or bus_err rising; per-event activity is accumulated in between.
   logic [31:0] prev_pc, prev_ret;
   logic        prev_be;
   int          m_rf, m_dreq, m_dwe, m_trap, m_cyc, ev_n = 0;
   rec_t        want;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_pc = pc; prev_ret = instret; prev_be = bus_err;
         m_rf = 0; m_dreq = 0; m_dwe = 0; m_trap = 0; m_cyc = 0;
      end else begin
         if (pc !== prev_pc || instret !== prev_ret || (bus_err && !prev_be)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event: pc=0x%08h instret=%0d bus_err=%0b", pc, instret, bus_err);
            end else begin
               want = exp_q.pop_front();
               checkOutput($sformatf("ev%0d_pc", ev_n), pc, want.pc);
               checkOutput($sformatf("ev%0d_instret", ev_n), instret, want.instret);
               checkOutput($sformatf("ev%0d_rf_we_pulses", ev_n), m_rf, want.rf);
               checkOutput($sformatf("ev%0d_dmem_req_cycles", ev_n), m_dreq, want.dreq);
               checkOutput($sformatf("ev%0d_dmem_we_cycles", ev_n), m_dwe, want.dwe);
               checkOutput($sformatf("ev%0d_trap_pulses", ev_n), m_trap, want.trapn);
               checkOutput($sformatf("ev%0d_latency", ev_n), m_cyc, want.cycles);
               checkOutput($sformatf("ev%0d_bus_err", ev_n), bus_err, want.bus_err);
               checkOutput($sformatf("ev%0d_halted", ev_n), halted, want.halted);
               checkOutput($sformatf("ev%0d_req_exclusive", ev_n), imem_req & dmem_req, 0);
            end
            ev_n++;
            m_rf = 0; m_dreq = 0; m_dwe = 0; m_trap = 0; m_cyc = 0;
         end
         prev_pc = pc; prev_ret = instret; prev_be = bus_err;
         m_cyc++;
         if (rf_we) m_rf++;
         if (dmem_req) m_dreq++;
         if (dmem_req && dmem_we) m_dwe++;
         if (trap) m_trap++;
      end
   end

   task automatic doReset();
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
      br_taken = 1'b0; pc_target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_inst_q", inst_q, 32'h0000_0013);
      checkOutput("rst_instret", instret, 32'h0);
      checkOutput("rst_imem_req", imem_req, 0);
      checkOutput("rst_dmem_req", dmem_req, 0);
      checkOutput("rst_rf_we", rf_we, 0);
      checkOutput("rst_flags", {halted, bus_err, trap}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic serveFetch(input logic [31:0] word, input int iwait);
      int n = 0;
      while (imem_req !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      if (imem_req !== 1'b1) begin
         checks++; errors++;
         $display("[TB] FAIL fetch_wait: actual imem_req=%0b required 1 within 64 cycles", imem_req);
         return;
      end
      repeat (iwait) begin @(posedge clk); #1; end
      imem_rdata = word; imem_ack = 1'b1;
      @(posedge clk);
      #1 imem_ack = 1'b0;
   endtask

   task automatic serveData(input int dwait);
      int n = 0;
      while (dmem_req !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      if (dmem_req !== 1'b1) begin
         checks++; errors++;
         $display("[TB] FAIL data_wait: actual dmem_req=%0b required 1 within 64 cycles", dmem_req);
         return;
      end
      repeat (dwait) begin @(posedge clk); #1; end
      dmem_ack = 1'b1;
      @(posedge clk);
      #1 dmem_ack = 1'b0;
   endtask

   // Branch inputs are applied once the word is in DECODE, so the previous instruction's EXEC never sees them.
   task automatic applyStimulus(input logic [31:0] word, input logic taken, input logic [31:0] target,
                                input int iwait, input int dwait, input logic is_mem, input rec_t exp_rec);
      exp_q.push_back(exp_rec);
      serveFetch(word, iwait);
      br_taken = taken; pc_target = target;
      if (is_mem) serveData(dwait);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] base_pc, base_ret;
      int          n;
      doReset();
      applyStimulus(32'h0050_0093, 1'b0, 32'h0,  0, 0, 1'b0, mk(32'h4,  1, 1, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0000_0463, 1'b1, 32'hB,  0, 0, 1'b0, mk(32'h8,  2, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0000_0463, 1'b0, 32'h40, 0, 0, 1'b0, mk(32'hC,  3, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0080_00EF, 1'b0, 32'h20, 0, 0, 1'b0, mk(32'h20, 4, 1, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0000_A103, 1'b0, 32'h0,  0, 3, 1'b1, mk(32'h24, 5, 1, 4, 0, 0, 8, 0, 0));
      applyStimulus(32'h0020_A023, 1'b0, 32'h0,  0, 0, 1'b1, mk(32'h28, 6, 0, 1, 1, 0, 5, 0, 0));
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      applyStimulus(32'h0000_007F, 1'b0, 32'h0,  0, 0, 1'b0, mk(32'h10, 6, 0, 0, 0, 1, 3, 0, 0));
      base_pc = 32'h10; base_ret = 32'd6;
`else
      applyStimulus(32'h0000_007F, 1'b0, 32'h0,  0, 0, 1'b0, mk(32'h2C, 7, 0, 0, 0, 0, 4, 0, 0));
      base_pc = 32'h2C; base_ret = 32'd7;
`endif
      applyStimulus(32'h0010_0013, 1'b0, 32'h0, 0, 0, 1'b0, mk(base_pc + 32'h4, base_ret + 1, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0000_8067, 1'b0, 32'hFFFF_FFFE, 0, 0, 1'b0,
                    mk(32'hFFFF_FFFC, base_ret + 2, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0050_0093, 1'b0, 32'h0, 0, 0, 1'b0, mk(32'h0, base_ret + 3, 1, 0, 0, 0, 4, 0, 0));
      applyStimulus(32'h0010_0073, 1'b0, 32'h0, 0, 0, 1'b0, mk(32'h4, base_ret + 4, 0, 0, 0, 0, 4, 0, 1));
      n = 0;
      repeat (24) begin @(posedge clk); #1; if (imem_req) n++; end
      checkOutput("halt_no_fetch_cycles", n, 0);
      checkOutput("halt_pc_frozen", pc, 32'h4);

      doReset();
      applyStimulus(32'h0050_0093, 1'b0, 32'h0, 0, 0, 1'b0, mk(32'h4, 1, 1, 0, 0, 0, 4, 0, 0));
      n = 0;
      while (imem_req !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      checkOutput("mid_fetch_req_seen", imem_req, 1);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checkOutput("mid_fetch_req_drop", imem_req, 0);
      checkOutput("mid_fetch_pc", pc, 32'h0);
      checkOutput("mid_fetch_instret", instret, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;

      applyStimulus(32'h0050_0093, 1'b0, 32'h0, 15, 0, 1'b0, mk(32'h4, 1, 1, 0, 0, 0, 19, 0, 0));
      exp_q.push_back(mk(32'h4, 1, 0, 0, 0, 0, 16, 1, 1));
      n = 0;
      while (bus_err !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      checkOutput("timeout_bus_err", bus_err, 1);
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("timeout_no_req", imem_req, 0);
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
